// File: rtl/register_file_param.sv
// Parameterised two-write/two-read register file with a self-clearing
// sequencer: the file is zeroed one entry per clock before it reports ready.
//
// state | meaning
// CLEAR | zeroing mem[cnt] each edge; reads return 0, writes are dropped
// READY | file usable; clr restarts the clear sequence
module register_file_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic              clr,
    output logic              rdy,
    output logic              err
);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic win1, win2, rin1, rin2;
    logic wz1, wz2, rz1, rz2;
    logic wv1, wv2;
    logic drop1, drop2;

    assign win1 = 32'(wa1) < DEPTH;
    assign win2 = 32'(wa2) < DEPTH;
    assign rin1 = 32'(ra1) < DEPTH;
    assign rin2 = 32'(ra2) < DEPTH;

    // Hardwired-zero register: writes are silently discarded, not errors.
    assign wz1 = (ZERO_R0 != 0) && (wa1 == '0);
    assign wz2 = (ZERO_R0 != 0) && (wa2 == '0);
    assign rz1 = (ZERO_R0 != 0) && (ra1 == '0);
    assign rz2 = (ZERO_R0 != 0) && (ra2 == '0);

    assign wv1 = we1 && rdy && win1 && !wz1;
    assign wv2 = we2 && rdy && win2 && !wz2;

    assign drop1 = we1 && (!rdy || !win1);
    assign drop2 = we2 && (!rdy || !win2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            rdy   <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= drop1 || drop2;
            case (state)
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= READY;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        rdy   <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wv2) mem[wa2] <= wd2;
                if (wv1) mem[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (rdy && rin1 && !rz1) begin
            if ((BYPASS != 0) && wv1 && (wa1 == ra1))
                rd1 = wd1;
            else if ((BYPASS != 0) && wv2 && (wa2 == ra1))
                rd1 = wd2;
            else
                rd1 = mem[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rdy && rin2 && !rz2) begin
            if ((BYPASS != 0) && wv1 && (wa1 == ra2))
                rd2 = wd1;
            else if ((BYPASS != 0) && wv2 && (wa2 == ra2))
                rd2 = wd2;
            else
                rd2 = mem[ra2];
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: three instances (defaults,
// hardwired-zero r0, six-entry file) share one stimulus stream.
module tb_register_file_param;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        we1, we2;
    logic [2:0]  ra1, ra2, wa1, wa2;
    logic [31:0] wd1, wd2;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
    logic        rdy_0, err_0, rdy_1, err_1, rdy_2, err_2;

    int vectors;
    int miscompares;

    register_file_param u0 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .clr(clr), .rdy(rdy_0), .err(err_0)
    );

    register_file_param #(.ZERO_R0(1)) u1 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .clr(clr), .rdy(rdy_1), .err(err_1)
    );

    register_file_param #(.DEPTH(6)) u2 (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_2), .rd2(rd2_2),
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .clr(clr), .rdy(rdy_2), .err(err_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 1'b0; we2 = 1'b0; clr = 1'b0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rdy0, exp_rdy2;
        idle();
        ra1 = 3'd3; ra2 = 3'd0;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (rdy_0 !== 1'b0 || err_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs rdy=%b err=%b expected rdy=0 err=0", rdy_0, err_0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_rdy0 = (i == 8) ? 32'd1 : 32'd0;
            exp_rdy2 = (i >= 6) ? 32'd1 : 32'd0;
            vectors++;
            if (rdy_0 !== exp_rdy0[0]) begin
                miscompares++;
                $display("FAIL clear_rdy edge=%0d rdy=%b expected %b", i, rdy_0, exp_rdy0[0]);
            end
            vectors++;
            if (rdy_2 !== exp_rdy2[0]) begin
                miscompares++;
                $display("FAIL clear_rdy_depth6 edge=%0d rdy=%b expected %b", i, rdy_2, exp_rdy2[0]);
            end
            if (i < 8) begin
                vectors++;
                if (rd1_0 !== 32'h0) begin
                    miscompares++;
                    $display("FAIL read_during_clear edge=%0d rd1=%h expected 0", i, rd1_0);
                end
            end
        end
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(7 - a);
            #1;
            vectors++;
            if (rd1_0 !== 32'h0 || rd2_0 !== 32'h0) begin
                miscompares++;
                $display("FAIL post_clear_read a=%0d rd1=%h rd2=%h expected 0", a, rd1_0, rd2_0);
            end
        end
    endtask

    task automatic test_bypass();
        we1 = 1'b1; wa1 = 3'd3; wd1 = 32'haaaaaaaa; ra1 = 3'd3;
        #1;
        vectors++;
        if (rd1_0 !== 32'haaaaaaaa) begin
            miscompares++;
            $display("FAIL bypass_same_cycle rd1=%h expected aaaaaaaa", rd1_0);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd1_0 !== 32'haaaaaaaa) begin
            miscompares++;
            $display("FAIL bypass_after_edge rd1=%h expected aaaaaaaa", rd1_0);
        end
    endtask

    task automatic test_collision();
        we1 = 1'b1; wa1 = 3'd5; wd1 = 32'h12345678;
        we2 = 1'b1; wa2 = 3'd5; wd2 = 32'h87654321;
        ra1 = 3'd5; ra2 = 3'd5;
        #1;
        vectors++;
        if (rd1_0 !== 32'h12345678 || rd2_0 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL collision_same_cycle rd1=%h rd2=%h expected 12345678", rd1_0, rd2_0);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd1_0 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL collision_after_edge rd1=%h expected 12345678", rd1_0);
        end
        vectors++;
        if (err_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_err err=%b expected 0", err_0);
        end
    endtask

    task automatic test_zero_r0();
        we1 = 1'b1; wa1 = 3'd0; wd1 = 32'h11111111; ra1 = 3'd0;
        #1;
        vectors++;
        if (rd1_1 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_r0_same_cycle rd1=%h expected 0", rd1_1);
        end
        vectors++;
        if (rd1_0 !== 32'h11111111) begin
            miscompares++;
            $display("FAIL r0_writable_same_cycle rd1=%h expected 11111111", rd1_0);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd1_1 !== 32'h0 || err_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_r0_after_edge rd1=%h err=%b expected 0/0", rd1_1, err_1);
        end
        vectors++;
        if (rd1_0 !== 32'h11111111) begin
            miscompares++;
            $display("FAIL r0_writable_after_edge rd1=%h expected 11111111", rd1_0);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_regs [6];
        exp_regs[0] = 32'h11111111; exp_regs[1] = 32'h0; exp_regs[2] = 32'h0;
        exp_regs[3] = 32'haaaaaaaa; exp_regs[4] = 32'h0; exp_regs[5] = 32'h12345678;
        we2 = 1'b1; wa2 = 3'd7; wd2 = 32'h77777777; ra2 = 3'd7;
        #1;
        vectors++;
        if (rd2_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read_same_cycle rd2=%h expected 0", rd2_2);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (err_2 !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_err_pulse err=%b expected 1", err_2);
        end
        vectors++;
        if (err_0 !== 1'b0 || rd2_0 !== 32'h77777777) begin
            miscompares++;
            $display("FAIL inrange_depth8 err=%b rd2=%h expected 0/77777777", err_0, rd2_0);
        end
        vectors++;
        if (rd2_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read_after rd2=%h expected 0", rd2_2);
        end
        tick();
        vectors++;
        if (err_2 !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_err_width err=%b expected 0", err_2);
        end
        for (int a = 0; a < 6; a++) begin
            ra1 = 3'(a);
            #1;
            vectors++;
            if (rd1_2 !== exp_regs[a]) begin
                miscompares++;
                $display("FAIL depth6_contents a=%0d rd1=%h expected %h", a, rd1_2, exp_regs[a]);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] exp_rdy;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (rdy_0 !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_enters_clear rdy=%b expected 0", rdy_0);
        end
        we1 = 1'b1; wa1 = 3'd2; wd1 = 32'hdeadbeef;
        tick();
        we1 = 1'b0;
        vectors++;
        if (err_0 !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_in_clear err=%b expected 1", err_0);
        end
        for (int i = 2; i <= 8; i++) begin
            clr = (i == 4);
            tick();
            clr = 1'b0;
            exp_rdy = (i == 8) ? 32'd1 : 32'd0;
            vectors++;
            if (rdy_0 !== exp_rdy[0]) begin
                miscompares++;
                $display("FAIL reclear_rdy edge=%0d rdy=%b expected %b", i, rdy_0, exp_rdy[0]);
            end
            if (i == 2) begin
                vectors++;
                if (err_0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drop_err_width err=%b expected 0", err_0);
                end
            end
        end
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(a);
            #1;
            vectors++;
            if (rd1_0 !== 32'h0 || rd2_0 !== 32'h0) begin
                miscompares++;
                $display("FAIL reclear_contents a=%0d rd1=%h rd2=%h expected 0", a, rd1_0, rd2_0);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        ra1 = '0;
        ra2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_zero_r0();
        test_out_of_range();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, number of registers, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter ZERO_R0, default 0; when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, reads forward same-cycle write data.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have ports ra1, ra2  input  ADDR_W  read addresses.
REQ-009 SHALL have ports rd1, rd2  output  DATA_W  read data (combinational from ra*, memory, write ports).
REQ-010 SHALL have ports we1, we2  input  1  write enables (port 1 higher priority).
REQ-011 SHALL have ports wa1, wa2  input  ADDR_W  write addresses.
REQ-012 SHALL have ports wd1, wd2  input  DATA_W  write data.
REQ-013 SHALL have port clr  input  1  request to zero the whole file.
REQ-014 SHALL have port rdy  output  1  registered; 1 = READY state, file usable.
REQ-015 SHALL have port err  output  1  registered one-cycle pulse flagging a dropped write.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and READY, with a clear counter cnt of ADDR_W bits.
REQ-017 In CLEAR, each rising edge with rst=0 SHALL write 0 to mem[cnt] and increment cnt; at cnt==DEPTH-1 the same edge SHALL set state=READY, rdy=1, cnt=0.
REQ-018 Clear sequence SHALL therefore take exactly DEPTH edges after rst deasserts (or after entering CLEAR).
REQ-019 In READY, clr=1 at an edge SHALL set state=CLEAR, cnt=0, rdy=0 on that edge; no register write from clr on that edge other than normal port writes.
REQ-020 clr while in CLEAR SHALL be ignored (no counter restart).
REQ-021 A write on port n SHALL be valid iff wen=1, rdy=1, wan<DEPTH, and not (ZERO_R0=1 and wan==0); valid writes update mem[wan]<=wdn at the edge.
REQ-022 If both writes are valid with wa1==wa2, only port 1 SHALL take effect.
REQ-023 Read rdn SHALL be 0 when rdy=0, when ran>=DEPTH, or when ZERO_R0=1 and ran==0.
REQ-024 Otherwise, with BYPASS=1, rdn SHALL return wd1 if write 1 valid and wa1==ran, else wd2 if write 2 valid and wa2==ran, else mem[ran].
REQ-025 With BYPASS=0, rdn SHALL return mem[ran] (new value visible the cycle after the write edge).
REQ-026 err SHALL be 1 for exactly the cycle after an edge where any port had wen=1 and its write was not valid due to rdy=0 or wan>=DEPTH; writes to register 0 under ZERO_R0=1 SHALL NOT raise err.
REQ-027 Simultaneous clr and valid writes in READY SHALL perform the writes, then enter CLEAR (cleared values overwrite them).

Reset
REQ-028 rst=1 at an edge SHALL set state=CLEAR, cnt=0, rdy=0, err=0; memory contents untouched on that edge.
REQ-029 rst asserted mid-clear or in READY SHALL restart the clear sequence from address 0 after release.
REQ-030 All outputs SHALL read 0 from the first reset edge until rdy=1.

Verification
REQ-031 rst=1 two edges then 0, defaults -> rdy=0 for 8 edges, rdy=1 after 8th, all rd1/rd2 reads = 0.
REQ-032 READY, we1=1 wa1=3 wd1=32'haaaaaaaa, ra1=3 same cycle -> rd1=32'haaaaaaaa before edge (bypass) and after edge with we1=0.
REQ-033 we1=1 wa1=5 wd1=32'h12345678, we2=1 wa2=5 wd2=32'h87654321 -> rd1 (ra1=5) = 32'h12345678 same cycle and after edge; err=0.
REQ-034 ZERO_R0=1, we1=1 wa1=0 wd1=32'h11111111 -> rd1 (ra1=0) = 0 both cycles, err=0.
REQ-035 DEPTH=6 ADDR_W=3, we2=1 wa2=7 wd2=32'h77777777 -> err=1 for one cycle, ra2=7 reads 0, registers 0-5 unchanged.
REQ-036 After writes, clr=1 one cycle -> rdy=0 next cycle; we1=1 during CLEAR dropped with err pulse; rdy=1 after 8 edges, all registers read 0.
